uarttx_simple: RTL and testbench
================================

Name: uarttx_simple

Overview:
- 8-bit UART transmitter; the transmit-side counterpart of the team's UART receiver. Same baud-counter scheme and debug outputs.
- Serialises one byte per frame: start bit (0), 8 data bits LSB first, optional even parity bit, STOP_BITS stop bits (1).
- Sits between a byte source using a valid/ready handshake and the FPGA TX pin; line idles high.

Parameters:
- BAUD_PER, 10416: bit period is BAUD_PER+1 clk cycles (9600 baud at 100 MHz).
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  transmit enable; gates acceptance of new bytes only.
- din  input  8  byte to send; sampled at acceptance.
- din_valid  input  1  source has a byte on din.
- din_ready  output  1  block can accept a byte.
- tx  output  1  serial line, registered.
- busy  output  1  frame in progress.
- out_state  output  3  current FSM state (debug).
- out_bit_ctr  output  3  data bit index (debug).

Behaviour:
- Reset, asynchronous with nrst=0: tx=1, busy=0, din_ready=0 during reset, state=S_IDLE, bit_ctr=0, baud_ctr=0, shift register=0.
- din_ready = en & (state==S_IDLE). This is combinational from registered state.
- Acceptance happens at a posedge with din_valid & din_ready.
  - din is latched, baud_ctr is cleared to 0, state goes to S_START, and tx=0 from the next cycle.
- Baud tick: baud_ctr counts 0..BAUD_PER and ticks when it equals BAUD_PER, then wraps to 0.
  - It is held at 0 in S_IDLE.
  - Every bit therefore lasts exactly BAUD_PER+1 cycles.
- FSM states: S_IDLE=0, S_START=1, S_DATA=2, S_PARITY=3, S_STOP=4. Transitions occur only on a tick, except IDLE->START, which occurs on acceptance.
  - S_START: tx=0. On tick go to S_DATA with bit_ctr=0.
  - S_DATA: tx=shreg[0]. On tick, shift right; if bit_ctr==7, go to S_PARITY (macro on) or S_STOP (macro off); else bit_ctr+1.
  - S_PARITY: tx=even parity of latched byte. On tick go to S_STOP.
  - S_STOP: tx=1. Counts STOP_BITS ticks, then goes to S_IDLE.
- tx is registered and changes on the same edge as the state/bit transition.
- busy=1 in every state except S_IDLE.
- Back-to-back transfers: din_ready rises the cycle after the final stop tick.
  - With din_valid held high, acceptance is on that cycle's edge.
  - The stop bit is therefore extended by exactly 1 cycle (minimum inter-frame gap is 1 clk).
- en deasserted mid-frame: the frame completes normally; no new byte is accepted until en=1.
- din and din_valid changes while busy are ignored.
- Reset mid-frame: tx returns to 1 immediately (asynchronous) and all state clears. No partial frame resumes.
- bit_ctr is 3 bits wide and wraps naturally. It is reset to 0 on entry to S_DATA.

Optional Feature:
- Macro: UARTTX_PARITY_EN.
- Defined: S_PARITY is used. One extra bit = XOR of the 8 latched data bits (even parity), giving 11 bits per frame with STOP_BITS=1.
- Undefined: S_PARITY is unreachable and its logic is not compiled, giving 10 bits per frame. out_state encoding is unchanged.

Test Plan (BAUD_PER=3, i.e. 4 clk per bit, unless noted):
- Reset: hold nrst=0 with din_valid=1 and en=1 → tx=1, busy=0, din_ready=0. Release → din_ready=1 the next cycle, and the first byte is accepted on the following edge.
- Single byte, no parity: send 0x55 → tx bits 0,1,0,1,0,1,0,1,0,1, each exactly 4 cycles. busy is high for 40 cycles, then din_ready=1.
- Parity (UARTTX_PARITY_EN defined): send 0xA7 → data 1,1,1,0,0,1,0,1, parity bit=1, stop=1. busy is high for 44 cycles.
- Back-to-back with STOP_BITS=2: hold din_valid=1 with 0x00 then 0xFF → stop level lasts 4+4+1=9 cycles before the second start bit. Second frame: start=0, data 1×8 (32 cycles high), then stop.
- Enable gating: en=0 with din_valid=1 → no acceptance, tx stays 1. Drop en during the 3rd data bit of 0x3C → frame completes correctly, and the next byte waits for en=1.
- Mid-frame reset: assert nrst=0 during bit 4 of 0x0F → tx=1 asynchronously, out_state=0, out_bit_ctr=0. After release, 0x81 is sent cleanly as 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uarttx_simple.sv
// uarttx_simple: 8-bit UART transmitter, start/8N/[even parity]/stop.
// Ports: clk, nrst (async, active-low); en gates acceptance; din/din_valid/
//   din_ready byte handshake; tx serial out (idle high, registered);
//   busy frame active; out_state/out_bit_ctr debug taps.
// Optional macro UARTTX_PARITY_EN adds an even parity bit after data.
module uarttx_simple #(
  parameter int BAUD_PER  = 10416,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] out_state,
  output logic [2:0] out_bit_ctr
);

  localparam int BW = (BAUD_PER < 1) ? 1 : $clog2(BAUD_PER + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_PER);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic            tx_q;
  logic            stop_q;
  logic            run_q;
`ifdef UARTTX_PARITY_EN
  logic            par_q;
`endif

  logic tick;
  assign tick = (baud_q == BAUD_MAX);

  // run_q keeps din_ready low while reset is held and for the
  // first edge after release, even though state is already IDLE.
  assign din_ready   = en & run_q & (state_q == S_IDLE);
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE);
  assign out_state   = state_q;
  assign out_bit_ctr = bit_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      tx_q    <= 1'b1;
      stop_q  <= 1'b0;
      run_q   <= 1'b0;
`ifdef UARTTX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      if (state_q == S_IDLE || tick) begin
        baud_q <= '0;
      end else begin
        baud_q <= baud_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (din_valid && din_ready) begin
            sh_q    <= din;
`ifdef UARTTX_PARITY_EN
            par_q   <= ^din;
`endif
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            state_q <= S_DATA;
            bit_q   <= 3'd0;
            tx_q    <= sh_q[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            sh_q <= {1'b0, sh_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef UARTTX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
              stop_q  <= 1'b0;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= sh_q[1];
            end
          end
        end
`ifdef UARTTX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (stop_q == STOP_LAST) begin
              state_q <= S_IDLE;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uarttx_simple.sv
// tb_uarttx_simple: vectors, corner sequences and random traffic
// checked against a waveform-level model of the UART frame.
module tb_uarttx_simple;

  localparam int B   = 3;
  localparam int CPB = B + 1;
`ifdef UARTTX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB1 = 10 + PB;
  localparam int FL  = NB1 * CPB;
  localparam int F2S = (11 + PB) * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] din = 8'h55;
  logic       din_valid = 1'b1;
  logic       rdy1, tx1, busy1;
  logic [2:0] st1, bc1;
  logic [7:0] d2 = 8'h00;
  logic       v2 = 1'b0;
  logic       rdy2, tx2, busy2;
  logic [2:0] st2, bc2;

  uarttx_simple #(.BAUD_PER(B), .STOP_BITS(1)) u1 (
    .clk(clk), .nrst(nrst), .en(en), .din(din),
    .din_valid(din_valid), .din_ready(rdy1), .tx(tx1),
    .busy(busy1), .out_state(st1), .out_bit_ctr(bc1));

  uarttx_simple #(.BAUD_PER(B), .STOP_BITS(2)) u2 (
    .clk(clk), .nrst(nrst), .en(en), .din(d2),
    .din_valid(v2), .din_ready(rdy2), .tx(tx2),
    .busy(busy2), .out_state(st2), .out_bit_ctr(bc2));

  int total = 0;
  int bad = 0;
  bit started = 1'b0;
  bit q[$];

  typedef struct {
    logic [7:0] d;
    logic [0:9] fr;
    logic       par;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PB == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic push_frame(input logic [7:0] b);
    for (int k = 0; k < NB1; k++)
      for (int c = 0; c < CPB; c++) q.push_back(fbit(b, k));
  endtask

  task automatic step();
    logic acc;
    int k;
    logic [2:0] es;
    acc = din_valid && en && started && (q.size() == 0);
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (acc) push_frame(din);
    started = 1'b1;
    #1;
    if (q.size() == 0) begin
      chk("tx", tx1, 1);
      chk("busy", busy1, 0);
      chk("rdy", rdy1, en);
      chk("st", st1, 0);
    end else begin
      k = (FL - q.size()) / CPB;
      chk("tx", tx1, q[0]);
      chk("busy", busy1, 1);
      chk("rdy", rdy1, 0);
      es = (k == 0) ? 3'd1 : (k <= 8) ? 3'd2 :
           (PB == 1 && k == 9) ? 3'd3 : 3'd4;
      chk("st", st1, es);
      if (k >= 1 && k <= 8) chk("bc", bc1, k - 1);
    end
  endtask

  task automatic do_reset();
    #2 nrst = 1'b0;
    #1;
    chk("rst_tx", tx1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_rdy", rdy1, 0);
    chk("rst_st", st1, 0);
    chk("rst_bc", bc1, 0);
    chk("rst_tx2", tx2, 1);
    din_valid = 1'b1;
    en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rsth_rdy", rdy1, 0);
      chk("rsth_tx", tx1, 1);
      chk("rsth_busy", busy1, 0);
    end
    @(negedge clk);
    nrst = 1'b1;
    q.delete();
    started = 1'b0;
    step();
    chk("rel_rdy", rdy1, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic e;
    int nbusy;
    nbusy = 0;
    din = v.d;
    din_valid = 1'b1;
    en = 1'b1;
    for (int k = 0; k < NB1; k++) begin
      if (k < 9) e = v.fr[k];
      else if (PB == 1 && k == 9) e = v.par;
      else e = v.fr[9];
      for (int c = 0; c < CPB; c++) begin
        step();
        din_valid = 1'b0;
        chk($sformatf("v%02h_b%0d", v.d, k), tx1, e);
        if (busy1 === 1'b1) nbusy++;
      end
    end
    step();
    chk("vec_busylen", nbusy, FL);
    chk("vec_end_rdy", rdy1, 1);
  endtask

  vec_t vt[7];
  logic rec[128];
  logic recb[128];
  logic recr[128];

  initial begin
    int cnt;
    logic e;
    vt[0] = '{8'h81, 10'b0100000011, 1'b0};
    vt[1] = '{8'h55, 10'b0101010101, 1'b0};
    vt[2] = '{8'hA7, 10'b0111001011, 1'b1};
    vt[3] = '{8'h3C, 10'b0001111001, 1'b0};
    vt[4] = '{8'h0F, 10'b0111100001, 1'b0};
    vt[5] = '{8'h00, 10'b0000000001, 1'b0};
    vt[6] = '{8'hFF, 10'b0111111111, 1'b0};

    do_reset();
    step();
    chk("first_acc_st", st1, 1);
    chk("first_acc_tx", tx1, 0);
    din_valid = 1'b0;
    repeat (FL) step();
    run_vec(vt[1]);
    run_vec(vt[2]);

    // back-to-back on the two-stop-bit instance
    v2 = 1'b1;
    d2 = 8'h00;
    step();
    d2 = 8'hFF;
    for (int i = 0; i < 2 * F2S + 7; i++) begin
      if (i > 0) step();
      rec[i] = tx2;
      recb[i] = busy2;
      recr[i] = rdy2;
      if (i == F2S + 1) v2 = 1'b0;
    end
    for (int i = 0; i < 2 * F2S + 7; i++) begin
      if (i < F2S) e = fbit(8'h00, i / CPB);
      else if (i == F2S) e = 1'b1;
      else if (i <= 2 * F2S) e = fbit(8'hFF, (i - F2S - 1) / CPB);
      else e = 1'b1;
      chk($sformatf("b2b_%0d", i), rec[i], e);
    end
    cnt = 0;
    for (int j = F2S; j >= 0 && rec[j] === 1'b1; j--) cnt++;
    chk("b2b_stop_len", cnt, 2 * CPB + 1);
    chk("b2b_gap_busy", recb[F2S], 0);
    chk("b2b_gap_rdy", recr[F2S], 1);
    chk("b2b_start2", rec[F2S + 1], 0);
    cnt = 0;
    for (int j = F2S + 1 + CPB; j < F2S + 1 + 9 * CPB; j++)
      if (rec[j] === 1'b1) cnt++;
    chk("b2b_ones", cnt, 8 * CPB);

    // enable gating
    en = 1'b0;
    din = 8'h3C;
    din_valid = 1'b1;
    repeat (10) step();
    chk("gate_st", st1, 0);
    en = 1'b1;
    step();
    chk("gate_acc_st", st1, 1);
    repeat (3 * CPB + 1) step();
    en = 1'b0;
    din = 8'hC3;
    repeat (FL) step();
    chk("gate_idle_busy", busy1, 0);
    chk("gate_idle_rdy", rdy1, 0);
    en = 1'b1;
    step();
    chk("gate_resume_st", st1, 1);
    din_valid = 1'b0;
    repeat (FL + 1) step();

    // reset mid-frame, then a clean frame
    din = 8'h0F;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (5 * CPB + 1) step();
    chk("pre_rst_tx", tx1, 0);
    do_reset();
    run_vec(vt[0]);
    for (int i = 3; i < 7; i++) run_vec(vt[i]);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      din_valid = $urandom_range(0, 1);
      din = 8'($urandom);
      step();
    end
    din_valid = 1'b0;
    en = 1'b1;
    repeat (FL + 2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
